// File: rtl/wb_initiator.sv
// Wishbone classic single-cycle initiator: command in, one bus cycle out, one response back.
// Latency: bus cycle starts 1 cycle after handshake; response 1 cycle after ack/timeout; stalls on rsp_ready.
module wb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic        ack_i,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] tmo_q, tmo_d;

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = BUS;
          req_ready_d = 1'b0;
          cyc_d       = 1'b1;
          we_d        = req_we;
          addr_d      = req_addr;
          data_d      = req_we ? req_wdata : 32'h0;
          tmo_d       = 16'h0;
        end else begin
          // ready comes up on the first edge after reset release
          req_ready_d = 1'b1;
        end
      end
      BUS: begin
        if (ack_i) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : data_i;
          rsp_err_d   = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      data_q      <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      err_count_q <= 16'h0;
      tmo_q       <= 16'h0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
      tmo_q       <= tmo_d;
    end
  end

  assign req_ready = req_ready_q;
  assign cyc_o     = cyc_q;
  assign stb_o     = cyc_q;
  assign we_o      = we_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;

endmodule
